coeff_encode_tx: RTL
====================

Name: coeff_encode_tx

Overview:
- Transmit-side counterpart of the coefficient decoder.
- Accepts a coefficient as a separate sign flag and 8-bit value, and packs it into the 9-bit coefficient code {sign, value}.
- Zero-extends the code to a 16-bit word and shifts it out serially, MSB first, with a one-bit frame marker. The serial format matches what the MSDAP serial receiver and coefficient loader expect.
- Includes a 2-entry input buffer so the producer can run ahead of the serial link.

Parameters:
- WORD_W, 16, serial word length in bits; the coefficient occupies bits [8:0], bits [WORD_W-1:9] are sent as 0.
- VALUE_W, 8, width of the coefficient value field; code width is VALUE_W+1.
- CNT_W, 10, width of the sent-word counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a coefficient.
- in_ready  output  1  buffer can accept; a transfer occurs on a cycle with in_valid & in_ready.
- sign  input  1  coefficient sign (1 = negative term).
- value  input  VALUE_W  coefficient value field.
- bit_en  input  1  serial bit strobe, one clk-cycle pulse per bit period.
- tx_data  output  1  serial data, registered.
- tx_frame  output  1  high during the bit period carrying a word's MSB, registered.
- busy  output  1  high while in SHIFT or buffer non-empty.
- sent_count  output  CNT_W  number of words fully transmitted, wraps.

Behaviour:
- Reset (synchronous, active-high):
  - Buffer emptied, state IDLE, shift register 0, bit counter 0.
  - tx_data=0, tx_frame=0, sent_count=0, busy=0, in_ready=1 on the cycle after reset deasserts.
- Reset mid-word aborts the word immediately. No partial completion, and sent_count is not incremented.
- Buffer: 2-entry FIFO of (VALUE_W+1)-bit codes {sign, value}.
  - in_ready = not full, combinational from registered occupancy.
  - Push on in_valid & in_ready. Pushes while full are impossible because in_ready=0.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- State machine, IDLE / SHIFT:
  - IDLE, buffer non-empty: pop the head, load shreg = {zeros, code}, bitcnt = WORD_W-1, go to SHIFT. This is a load cycle and does not depend on bit_en.
  - IDLE, on bit_en: tx_data<=0, tx_frame<=0.
  - SHIFT, on bit_en:
    - tx_data<=shreg[WORD_W-1].
    - tx_frame<=(bitcnt==WORD_W-1).
    - shreg shifts left one place with 0 fill.
    - bitcnt decrements.
  - SHIFT, on bit_en with bitcnt==0 (last bit):
    - sent_count increments, wrapping from 2^CNT_W-1 to 0.
    - If the buffer is non-empty in that same cycle: pop and reload, bitcnt=WORD_W-1, stay in SHIFT. Words go back-to-back with no idle bit.
    - Otherwise go to IDLE.
  - SHIFT without bit_en: all state holds.
- tx_data and tx_frame change only on bit_en cycles (or reset). tx_frame is therefore high for exactly one bit period per word.
- Latency: a coefficient accepted into an empty buffer while IDLE is loaded on the next clk. Its MSB appears on tx_data after the first bit_en strictly after the load cycle.
- busy = (state==SHIFT) | (occupancy != 0).
- Word ordering is strict FIFO; no word is dropped or duplicated.
- bit_en asserted on every cycle is legal (full-rate shifting).

Test Plan:
- Reset, then hold bit_en=0 -> in_ready=1, busy=0, tx_data=0, tx_frame=0, sent_count=0.
- Push sign=1, value=8'hA5, then pulse bit_en 16 times -> tx_data sequence 0000000 1 10100101 MSB first; tx_frame high only on bit 1; sent_count=1; busy=0 afterwards.
- Push three codes {0,8'h01}, {1,8'hFF}, {0,8'h80} with bit_en=0 -> first loads into shreg, the next two fill the buffer, in_ready=0. Run bit_en every cycle -> 48 contiguous bits, three tx_frame pulses 16 bits apart, sent_count=3.
- Push coinciding with the last-bit bit_en of the current word and buffer empty before it -> the new word starts on the next bit period with no idle bit; tx_frame pulse exactly 16 bit_en after the previous one.
- Assert reset at bit 7 of a word with the buffer full -> the next cycle shows empty buffer, IDLE, tx_data=0, sent_count unchanged from its pre-reset value of 0 (freshly reset); a subsequent push transmits normally.
- Preload sent_count to 1023 by transmitting 1023 words of value=8'h00, then one more -> sent_count wraps to 0.

Source files
------------

// File: rtl/coeff_encode_tx.sv
// Coefficient serializer: packs {sign, value} into a zero-extended word and shifts it
// out MSB first with a one-bit frame marker, behind a 2-entry input FIFO.
module coeff_encode_tx #(
  parameter int WORD_W  = 16,
  parameter int VALUE_W = 8,
  parameter int CNT_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign,
  input  logic [VALUE_W-1:0] value,
  input  logic               bit_en,
  output logic               tx_data,
  output logic               tx_frame,
  output logic               busy,
  output logic [CNT_W-1:0]   sent_count
);
  localparam int CODE_W = VALUE_W + 1;
  localparam int BCNT_W = $clog2(WORD_W);

  typedef struct packed {
    logic               sign;
    logic [VALUE_W-1:0] value;
  } code_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, nstate;
  code_t               in_code, load_code;
  code_t               mem [2];
  logic                wp, rp;
  logic [1:0]          occ;
  logic [WORD_W-1:0]   shreg;
  logic [BCNT_W-1:0]   bitcnt;
  logic                push, fifo_push, pop, load, bypass, last, empty;

  assign in_code   = '{sign: sign, value: value};
  assign in_ready  = (occ != 2'd2);
  assign empty     = (occ == 2'd0);
  assign push      = in_valid & in_ready;
  assign last      = (state == SHIFT) & bit_en & (bitcnt == '0);
  // A word accepted on the last-bit cycle of an otherwise empty link goes straight
  // into the shift register, so it follows with no idle bit.
  assign fifo_push = push & ~bypass;
  assign load_code = bypass ? in_code : mem[rp];
  assign busy      = (state == SHIFT) | ~empty;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (!empty) nstate = SHIFT;
      SHIFT: if (last && empty && !push) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    pop    = 1'b0;
    bypass = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        load = 1'b1;
        pop  = 1'b1;
      end
      SHIFT: if (last) begin
        if (!empty) begin
          load = 1'b1;
          pop  = 1'b1;
        end else if (push) begin
          load   = 1'b1;
          bypass = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wp] <= in_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (fifo_push) wp <= ~wp;
      if (pop)       rp <= ~rp;
      if (fifo_push && !pop)      occ <= occ + 2'd1;
      else if (pop && !fifo_push) occ <= occ - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bitcnt     <= '0;
      tx_data    <= 1'b0;
      tx_frame   <= 1'b0;
      sent_count <= '0;
    end else begin
      if (bit_en) begin
        if (state == SHIFT) begin
          tx_data  <= shreg[WORD_W-1];
          tx_frame <= (bitcnt == BCNT_W'(WORD_W-1));
        end else begin
          tx_data  <= 1'b0;
          tx_frame <= 1'b0;
        end
      end
      if (load) begin
        shreg  <= {{(WORD_W-CODE_W){1'b0}}, load_code};
        bitcnt <= BCNT_W'(WORD_W-1);
      end else if (state == SHIFT && bit_en) begin
        shreg  <= {shreg[WORD_W-2:0], 1'b0};
        bitcnt <= bitcnt - BCNT_W'(1);
      end
      if (last) sent_count <= sent_count + CNT_W'(1);
    end
  end
endmodule
